decode_dispatch_ctrl: RTL
=========================

# decode_dispatch_ctrl

Flow controller between the 4-wide decode stage and the issue queue. It accepts one decoded bundle per cycle and pushes as many lanes as the issue queue has room for. Any lanes that do not fit go into an in-order holding buffer, and upstream is backpressured until that buffer drains. It drives the issue-queue push count, handles pipeline flush, and keeps a saturating backpressure-stall counter for performance monitoring.

## Interface

Parameters:
- LANES, 4, bundle width. The design is fixed at 4; other values are unsupported.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock. This is the only clock.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  pipeline flush on mispredict or exception.
- in_valid  in  1  decoded bundle present.
- in_count  in  3  number of valid lanes, 1..4. Lanes 0..in_count-1 are valid and in program order.
- in_elem  in  ISSUE_QUEUE_ELEMENT[3:0]  decoded bundle from decode.
- in_ready  out  1  bundle is accepted this cycle when in_valid && in_ready.
- iq_size_left  in  3  free issue-queue slots. Values above 4 are clamped to 4.
- iq_push_number  out  3  lanes pushed this cycle, 0..4.
- iq_push_element  out  ISSUE_QUEUE_ELEMENT[3:0]  pushed lanes, compacted from lane 0.
- stall_cnt  out  STALL_CNT_W  count of backpressure cycles.

## Operation

- State machine: EMPTY when hold_cnt==0; HOLD when hold_cnt is 1..4.
- Registers:
  - hold_elem[3:0]: held lanes, compacted from lane 0.
  - hold_cnt: 3 bits.
  - stall_cnt.
- Source selection for the cycle:
  - HOLD: the source is the holding buffer, with src_cnt = hold_cnt.
  - EMPTY with in_valid and in_count ≥ 1: the source is the input, with src_cnt = in_count.
  - Otherwise src_cnt = 0.
- Push count: push = min(src_cnt, min(iq_size_left, 4)).
  - iq_push_number = push.
  - iq_push_element lanes 0..push-1 are source lanes 0..push-1. The remaining lanes are driven to zero.
- in_ready = (state==EMPTY). Input is never accepted while HOLD, so held lanes always issue before newer lanes and program order is preserved.
- Update in HOLD:
  - hold_elem shifts down by push.
  - hold_cnt ← hold_cnt − push.
  - When hold_cnt reaches 0, the state becomes EMPTY.
- Update in EMPTY when the input is accepted:
  - If push == in_count, the state stays EMPTY.
  - Otherwise in_elem lanes push..in_count-1 are captured into hold_elem lanes 0.., hold_cnt ← in_count − push, and the state becomes HOLD.
- Lanes of hold_elem at or above hold_cnt are don't-care internally, but they are never driven onto iq_push_element.
- stall_cnt increments in every cycle where src_cnt > 0 and push < src_cnt.
  - It saturates at all-ones.
  - It is cleared only by rst; flush does not clear it.
- Flush has priority over everything except rst:
  - iq_push_number = 0 and iq_push_element = 0.
  - hold_cnt ← 0 and the state becomes EMPTY.
  - in_ready = 1, and any input offered in the same cycle is discarded.
  - stall_cnt does not increment.
- in_valid with in_count = 0 is treated as no input. in_count > 4 is illegal and is covered by a bench assertion.

## Timing

- Reset values (next edge after rst=1):
  - hold_cnt = 0, state EMPTY.
  - stall_cnt = 0.
  - While rst is high, iq_push_number = 0, iq_push_element = 0, in_ready = 0.
- Zero latency: iq_push_number and iq_push_element are combinational from in_elem/in_count, iq_size_left, and the held state. A bundle accepted in cycle N reaches the issue queue in cycle N if it fits.
- Held lanes issue no earlier than cycle N+1.
- Maximum residency is unbounded: lanes stay held while iq_size_left = 0.
- A full hold (4 lanes, iq_size_left = 0) keeps in_ready = 0 indefinitely. There is no overflow path.
- Simultaneous flush and push in the same cycle: flush wins and nothing is pushed.
- rst asserted mid-HOLD discards the held lanes on that edge.
- The issue queue must update iq_size_left by the next cycle. This block does not track in-flight pushes.

## Test plan

- Free flow:
  - Stimulus: in_count=4 with iq_size_left=7 every cycle for 10 cycles.
  - Required: iq_push_number=4 every cycle, in_ready=1 throughout, stall_cnt=0.
- Partial fit:
  - Stimulus: in_count=4 with lanes A,B,C,D and iq_size_left=1.
  - Cycle 0: push 1 (A), hold_cnt becomes 3, in_ready=0 in cycle 1.
  - Cycle 1 with iq_size_left=2: push B,C in lanes 0..1.
  - Cycle 2 with iq_size_left=4: push D alone. in_ready returns to 1 in cycle 3.
  - stall_cnt=2.
- Zero space:
  - Stimulus: in_count=3 with iq_size_left=0 for 5 cycles, then 4.
  - Required: push=0 for 5 cycles, then 3 lanes in the original order. stall_cnt=5.
- Flush mid-hold:
  - Stimulus: hold_cnt=2, then flush=1 with in_valid=1 and in_count=4 in the same cycle.
  - Required: iq_push_number=0, the input is discarded, and the state is EMPTY in the next cycle. stall_cnt is unchanged.
- Reset mid-hold:
  - Stimulus: rst during hold_cnt=3.
  - Required: hold_cnt=0 and stall_cnt=0 after the edge. iq_push_number=0 while rst is high.
- Counter saturation:
  - Stimulus: force 2^16+5 backpressure cycles.
  - Required: stall_cnt is 0xFFFF and does not wrap.

Source files
------------

// File: rtl/decode_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_dispatch_ctrl
// Brief    : 4-wide decode-to-issue-queue flow controller with in-order
//            holding buffer, flush handling and saturating stall counter.
// Revision : 1.0
// ============================================================================
module decode_dispatch_ctrl #(
    parameter int LANES       = 4,
    parameter int STALL_CNT_W = 16,
    parameter int ELEM_W      = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [2:0]                         in_count,
    input  logic [LANES-1:0][ELEM_W-1:0]       in_elem,
    output logic                               in_ready,
    input  logic [2:0]                         iq_size_left,
    output logic [2:0]                         iq_push_number,
    output logic [LANES-1:0][ELEM_W-1:0]       iq_push_element,
    output logic [STALL_CNT_W-1:0]             stall_cnt
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [2:0]             C_MAX_PUSH  = 3'd4;
    localparam logic [STALL_CNT_W-1:0] C_STALL_MAX = '1;

    state_t                         r_state;
    logic [2:0]                     r_hold_cnt;
    logic [LANES-1:0][ELEM_W-1:0]   r_hold_elem;
    logic [STALL_CNT_W-1:0]         r_stall_cnt;

    logic [2:0]                     w_iq_free;
    logic [2:0]                     w_src_cnt;
    logic [2:0]                     w_push;
    logic [2:0]                     w_hold_cnt_nxt;
    logic                           w_in_present;
    logic                           w_stall;
    logic                           w_block;
    state_t                         w_state_nxt;
    logic [LANES-1:0][ELEM_W-1:0]   w_src_elem;
    logic [LANES-1:0][ELEM_W-1:0]   w_hold_elem_nxt;

    always_comb begin
        w_iq_free    = (iq_size_left > C_MAX_PUSH) ? C_MAX_PUSH : iq_size_left;
        w_in_present = in_valid && (in_count != 3'd0);
        w_src_cnt    = 3'd0;
        w_src_elem   = in_elem;
        if (r_state == ST_HOLD) begin
            w_src_cnt  = r_hold_cnt;
            w_src_elem = r_hold_elem;
        end else if (w_in_present) begin
            w_src_cnt = in_count;
        end
        w_push  = (w_src_cnt < w_iq_free) ? w_src_cnt : w_iq_free;
        w_stall = (w_push < w_src_cnt);

        // Leftover lanes drop to lane 0: the same shift serves both draining
        // the hold buffer and capturing the unpushed tail of a new bundle.
        w_hold_elem_nxt = w_src_elem >> (ELEM_W * int'(w_push));
        w_hold_cnt_nxt  = w_src_cnt - w_push;
        w_state_nxt     = (w_hold_cnt_nxt != 3'd0) ? ST_HOLD : ST_EMPTY;
    end

    always_comb begin
        w_block         = rst || flush;
        in_ready        = !rst && (flush || (r_state == ST_EMPTY));
        iq_push_number  = w_block ? 3'd0 : w_push;
        iq_push_element = '0;
        if (!w_block) begin
            for (int i = 0; i < LANES; i++) begin
                if (3'(i) < w_push) begin
                    iq_push_element[i] = w_src_elem[i];
                end
            end
        end
        stall_cnt = r_stall_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_hold_cnt  <= 3'd0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_hold_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            if (w_stall && (r_stall_cnt != C_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    // Lanes at or above hold_cnt are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        r_hold_elem <= w_hold_elem_nxt;
    end

endmodule
`default_nettype wire
